// File: rtl/imuldiv_int_div_requester_if.sv
// Handshake bundle between the pipeline, the requester and the divider.
// slave: the requester's view; master: the environment driving it.
interface imuldiv_int_div_requester_if #(
    parameter int TAG_W = 4
);
    logic             op_val;
    logic             op_rdy;
    logic             op_fn;
    logic             op_rem;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] op_tag;

    logic             divreq_msg_fn;
    logic [31:0]      divreq_msg_a;
    logic [31:0]      divreq_msg_b;
    logic             divreq_val;
    logic             divreq_rdy;

    logic [63:0]      divresp_msg_result;
    logic             divresp_val;
    logic             divresp_rdy;

    logic             res_val;
    logic             res_rdy;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [7:0]       res_cycles;

    modport slave (
        input  op_val, op_fn, op_rem, op_a, op_b, op_tag,
        output op_rdy,
        output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
        input  divreq_rdy,
        input  divresp_msg_result, divresp_val,
        output divresp_rdy,
        output res_val, res_data, res_tag, res_cycles,
        input  res_rdy
    );

    modport master (
        output op_val, op_fn, op_rem, op_a, op_b, op_tag,
        input  op_rdy,
        input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
        output divreq_rdy,
        output divresp_msg_result, divresp_val,
        input  divresp_rdy,
        input  res_val, res_data, res_tag, res_cycles,
        output res_rdy
    );
endinterface

// File: rtl/imuldiv_int_div_requester.sv
// Requester adapter: one tagged div/rem op in flight to the iterative
// divider; divide-by-zero answered locally without a divider request.
module imuldiv_int_div_requester #(
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic reset,
    imuldiv_int_div_requester_if.slave io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             fn_q, fn_d;
    logic             rem_q, rem_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [7:0]       res_cycles_q, res_cycles_d;

    logic             accept;
    logic             by_zero;
    logic [7:0]       cnt_inc;

    assign accept  = (state_q == IDLE) && io.op_val;
    assign by_zero = (io.op_b == 32'd0);
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // State and datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fn_q         <= 1'b0;
            rem_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            res_data_q   <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            fn_q         <= fn_d;
            rem_q        <= rem_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            res_data_q   <= res_data_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    // Next-state: advance on each channel's handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (io.op_val) state_d = by_zero ? DONE : REQ;
            REQ:  if (io.divreq_rdy) state_d = WAIT;
            WAIT: if (io.divresp_val) state_d = DONE;
            DONE: if (io.res_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture op, count WAIT cycles, build the result.
    always_comb begin
        fn_d         = fn_q;
        rem_d        = rem_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        res_data_d   = res_data_q;
        res_cycles_d = res_cycles_q;
        if (accept) begin
            fn_d  = io.op_fn;
            rem_d = io.op_rem;
            a_d   = io.op_a;
            b_d   = io.op_b;
            tag_d = io.op_tag;
            cnt_d = '0;
            if (by_zero) begin
                res_data_d   = io.op_rem ? io.op_a : 32'hFFFF_FFFF;
                res_cycles_d = '0;
            end
        end else if (state_q == WAIT) begin
            cnt_d = cnt_inc;
            if (io.divresp_val) begin
                res_data_d   = rem_q ? io.divresp_msg_result[63:32]
                                     : io.divresp_msg_result[31:0];
                res_cycles_d = cnt_inc;
            end
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        io.op_rdy        = (state_q == IDLE);
        io.divreq_val    = (state_q == REQ);
        io.divresp_rdy   = (state_q == WAIT);
        io.res_val       = (state_q == DONE);
        io.divreq_msg_fn = fn_q;
        io.divreq_msg_a  = a_q;
        io.divreq_msg_b  = b_q;
        io.res_data      = res_data_q;
        io.res_tag       = tag_q;
        io.res_cycles    = res_cycles_q;
    end

endmodule

// File: tb/tb_imuldiv_int_div_requester.sv
// Bench for the divide requester: directed and random ops against a
// behavioural divider and result-selection model.
module tb_imuldiv_int_div_requester;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    imuldiv_int_div_requester_if #(.TAG_W(4)) dif ();

    imuldiv_int_div_requester #(.TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural divider: RISC-V style results, returned {rem, quo}.
    function automatic logic [63:0] div_model(input bit fn,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (fn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    task automatic run_op(input bit fn, input bit rem,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input int req_stall,
                          input int resp_wait, input int res_stall);
        logic [63:0] res;
        logic [31:0] exp_data;
        int          exp_cyc;
        res      = div_model(fn, a, b);
        exp_data = rem ? res[63:32] : res[31:0];
        exp_cyc  = (b == 0) ? 0 : ((resp_wait > 255) ? 255 : resp_wait);

        chk("op_rdy_idle", 64'(dif.op_rdy), 64'd1);
        dif.op_val = 1'b1;
        dif.op_fn  = fn;
        dif.op_rem = rem;
        dif.op_a   = a;
        dif.op_b   = b;
        dif.op_tag = tag;
        tick();
        dif.op_val = 1'b0;
        dif.op_a   = ~a;
        dif.op_b   = ~b;

        if (b != 0) begin
            chk("req_val", 64'(dif.divreq_val), 64'd1);
            chk("req_msg", {31'd0, dif.divreq_msg_fn,
                            dif.divreq_msg_a}, {31'd0, fn, a});
            chk("req_b", 64'(dif.divreq_msg_b), 64'(b));
            for (int i = 0; i < req_stall; i++) begin
                dif.divresp_val = 1'b1;
                dif.divresp_msg_result = 64'hDEAD_BEEF_0BAD_F00D;
                tick();
                dif.divresp_val = 1'b0;
                chk("req_hold", {dif.divreq_val, dif.op_rdy,
                                 dif.divresp_rdy, dif.divreq_msg_fn,
                                 dif.divreq_msg_a, 28'd0},
                                {1'b1, 1'b0, 1'b0, fn, a, 28'd0});
                chk("req_hold_b", 64'(dif.divreq_msg_b), 64'(b));
            end
            dif.divreq_rdy = 1'b1;
            tick();
            dif.divreq_rdy = 1'b0;
            chk("wait_ent", {62'd0, dif.divreq_val, dif.divresp_rdy},
                64'd1);
            for (int i = 1; i < resp_wait; i++) tick();
            chk("wait_rdy", {62'd0, dif.divresp_rdy, dif.res_val},
                64'd2);
            dif.divresp_val = 1'b1;
            dif.divresp_msg_result = res;
            tick();
            dif.divresp_val = 1'b0;
            dif.divresp_msg_result = '0;
        end else begin
            chk("bz_noreq", 64'(dif.divreq_val), 64'd0);
        end

        chk("res_val", {61'd0, dif.res_val, dif.op_rdy, dif.divresp_rdy},
            64'd4);
        chk("res_data", 64'(dif.res_data), 64'(exp_data));
        chk("res_tag", 64'(dif.res_tag), 64'(tag));
        chk("res_cyc", 64'(dif.res_cycles), 64'(exp_cyc));
        for (int i = 0; i < res_stall; i++) begin
            dif.op_val = 1'b1;
            tick();
            dif.op_val = 1'b0;
            chk("res_hold", {dif.res_val, dif.op_rdy, dif.divreq_val,
                             dif.res_tag, dif.res_cycles, 18'd0,
                             dif.res_data},
                {1'b1, 1'b0, 1'b0, tag, 8'(exp_cyc), 18'd0, exp_data});
        end
        dif.res_rdy = 1'b1;
        tick();
        dif.res_rdy = 1'b0;
        chk("back_idle", {62'd0, dif.op_rdy, dif.res_val}, 64'd2);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        dif.op_val = 0;
        dif.op_fn = 0;
        dif.op_rem = 0;
        dif.op_a = 0;
        dif.op_b = 0;
        dif.op_tag = 0;
        dif.divreq_rdy = 0;
        dif.divresp_val = 0;
        dif.divresp_msg_result = 0;
        dif.res_rdy = 0;
        reset = 1'b0;
        repeat (2) tick();

        chk("rst_ctl", {60'd0, dif.op_rdy, dif.divreq_val,
                        dif.divresp_rdy, dif.res_val}, 64'd8);
        chk("rst_res", {dif.res_data, 20'd0, dif.res_tag,
                        dif.res_cycles}, 64'd0);
        chk("rst_msg", {dif.divreq_msg_fn, 31'd0, dif.divreq_msg_a},
            64'd0);
        reset = 1'b1;
        tick();

        run_op(0, 0, 32'd7, 32'hFFFF_FFFE, 4'h5, 0, 2, 0);
        chk("sgn_quo", 64'(div_model(0, 7, 32'hFFFF_FFFE)),
            {32'd1, 32'hFFFF_FFFD});
        run_op(0, 1, 32'd7, 32'hFFFF_FFFE, 4'hA, 0, 1, 0);
        run_op(1, 0, 32'hFFFF_FFFF, 32'd16, 4'h3, 2, 4, 0);
        run_op(1, 1, 32'hFFFF_FFFF, 32'd16, 4'hC, 0, 3, 1);
        run_op(0, 0, 32'h1234_5678, 32'd0, 4'h9, 0, 0, 0);
        run_op(1, 1, 32'h1234_5678, 32'd0, 4'h6, 0, 0, 2);
        run_op(0, 1, 32'hFFFF_FF9C, 32'd7, 4'hE, 5, 6, 3);
        run_op(1, 0, 32'd1000, 32'd3, 4'h1, 0, 33, 0);
        run_op(0, 0, 32'd1000, 32'd3, 4'h2, 0, 300, 0);

        for (int n = 0; n < 20; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 28);
            run_op(1'($urandom), 1'($urandom), ra, rb, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(1, 40),
                   $urandom_range(0, 3));
        end

        dif.op_val = 1'b1;
        dif.op_fn  = 1'b1;
        dif.op_rem = 1'b1;
        dif.op_a   = 32'd99;
        dif.op_b   = 32'd10;
        dif.op_tag = 4'hF;
        tick();
        dif.op_val = 1'b0;
        dif.divreq_rdy = 1'b1;
        tick();
        dif.divreq_rdy = 1'b0;
        tick();
        chk("pre_rst_wait", 64'(dif.divresp_rdy), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ctl", {60'd0, dif.op_rdy, dif.divreq_val,
                            dif.divresp_rdy, dif.res_val}, 64'd8);
        chk("mid_rst_res", {dif.res_data, 20'd0, dif.res_tag,
                            dif.res_cycles}, 64'd0);
        chk("mid_rst_msg", {dif.divreq_msg_fn, 31'd0, dif.divreq_msg_a},
            64'd0);
        chk("mid_rst_b", 64'(dif.divreq_msg_b), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        run_op(0, 1, 32'hFFFF_FFF1, 32'd4, 4'h7, 1, 5, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
